// File: rtl/seq101_frame_ctrl_if.sv
// Word-in / frame-result handshake bundle for seq101_frame_ctrl.
// The master side is the producer/consumer; the slave side is the controller.
interface seq101_frame_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              hit;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, hit, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, hit, out_valid, out_count
  );
endinterface

// File: rtl/seq101_frame_ctrl.sv
// Frame controller: serializes words MSB-first through a non-overlapping
// "101" Mealy detector and reports a saturating per-frame match count.
module seq101_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  seq101_frame_ctrl_if.slave bus
);
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] BC_TOP = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2
  } det_e;

  state_e            state_q, state_d;
  det_e              det_q, det_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
  logic              hit_q, hit_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              bit_in;

  assign bit_in = sh_q[DATA_W-1];

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    sh_d    = sh_q;
    bc_d    = bc_q;
    last_d  = last_q;
    mcnt_d  = mcnt_q;
    hit_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_d    = bus.in_data;
          last_d  = bus.in_last;
          bc_d    = BC_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d = sh_q << 1;
        bc_d = bc_q - 1'b1;
        unique case (det_q)
          D0: det_d = bit_in ? D1 : D0;
          D1: det_d = bit_in ? D1 : D2;
          D2: begin
            det_d = D0;
            if (bit_in) begin
              hit_d = 1'b1;
              if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + 1'b1;
            end
          end
          default: det_d = D0;
        endcase
        if (bc_q == '0) state_d = last_q ? REPORT : IDLE;
      end
      REPORT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          mcnt_d  = '0;
          det_d   = D0;
        end
      end
      default: state_d = IDLE;
    endcase
    // handshake flags follow the next state so they are true flops
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      det_q       <= D0;
      sh_q        <= '0;
      bc_q        <= '0;
      last_q      <= 1'b0;
      mcnt_q      <= '0;
      hit_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      sh_q        <= sh_d;
      bc_q        <= bc_d;
      last_q      <= last_d;
      mcnt_q      <= mcnt_d;
      hit_q       <= hit_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.hit       = hit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = mcnt_q;
endmodule

// File: tb/tb_seq101_frame_ctrl.sv
// Randomized bench for seq101_frame_ctrl: two instances (CNT_W 8 and 2)
// share stimulus and are compared against a bit-string reference model.
module tb_seq101_frame_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic in_last;
  logic out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq101_frame_ctrl_if #(.DATA_W(DW), .CNT_W(8)) bus_a ();
  seq101_frame_ctrl_if #(.DATA_W(DW), .CNT_W(2)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  seq101_frame_ctrl #(.DATA_W(DW), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  seq101_frame_ctrl #(.DATA_W(DW), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leftmost non-overlapping search for "101" over the whole frame.
  function automatic void model(input bit fb[$], output bit hv[$],
                                output int n);
    int i;
    hv = {};
    foreach (fb[k]) hv.push_back(1'b0);
    n = 0;
    i = 0;
    while (i + 2 < fb.size()) begin
      if (fb[i] && !fb[i+1] && fb[i+2]) begin
        hv[i+2] = 1'b1;
        n++;
        i += 3;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic run_frame(input logic [DW-1:0] w[$], input int bp);
    bit fb[$];
    bit hv[$];
    int n;
    int ea, eb;
    bit lst;
    foreach (w[j])
      for (int b = DW - 1; b >= 0; b--) fb.push_back(w[j][b]);
    model(fb, hv, n);
    ea = (n > 255) ? 255 : n;
    eb = (n > 3) ? 3 : n;
    foreach (w[j]) begin
      lst = (j == w.size() - 1);
      check_eq("idle_rdy", bus_a.in_ready, 1);
      in_valid = 1'b1;
      in_data  = w[j];
      in_last  = lst;
      tick();
      check_eq("busy_rdy", bus_a.in_ready, 0);
      for (int k = 1; k <= DW; k++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        tick();
        check_eq("hit_a", bus_a.hit, hv[j*DW+k-1]);
        check_eq("hit_b", bus_b.hit, hv[j*DW+k-1]);
        if (k < DW) check_eq("early_ov", bus_a.out_valid, 0);
      end
      check_eq("end_ov", bus_a.out_valid, lst);
      check_eq("end_rdy", bus_a.in_ready, !lst);
    end
    for (int c = 0; c <= bp; c++) begin
      out_ready = (c == bp);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      check_eq("rep_ov", bus_a.out_valid, 1);
      check_eq("rep_rdy", bus_a.in_ready, 0);
      check_eq("cnt_a", bus_a.out_count, ea);
      check_eq("cnt_b", bus_b.out_count, eb);
      tick();
    end
    check_eq("post_ov", bus_a.out_valid, 0);
    check_eq("post_rdy", bus_a.in_ready, 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_rdy", bus_a.in_ready, 1);
    check_eq("rst_ov", bus_a.out_valid, 0);
    check_eq("rst_hit", bus_a.hit, 0);
    check_eq("rst_cnt", bus_a.out_count, 0);

    q = {8'b10100000};
    run_frame(q, 0);
    q = {8'b10101010};
    run_frame(q, 0);
    q = {8'b00000010, 8'b10000000};
    run_frame(q, 1);
    q = {8'b10101010, 8'b10101010};
    run_frame(q, 2);
    q = {8'b00101000};
    run_frame(q, 5);
    q = {8'b01010000};
    run_frame(q, 0);

    in_valid = 1'b1;
    in_data  = 8'b10101010;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("pre_rst_hit", bus_a.hit, (k == 3));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_rdy", bus_a.in_ready, 1);
    check_eq("mid_rst_ov", bus_a.out_valid, 0);
    check_eq("mid_rst_hit", bus_a.hit, 0);
    check_eq("mid_rst_cnt", bus_a.out_count, 0);
    q = {8'b10100000};
    run_frame(q, 0);

    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      q = {};
      for (int j = 0; j < nw; j++) q.push_back(DW'($urandom));
      run_frame(q, $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
